// File: rtl/apb_rx_fifo_if.sv
// rtl/apb_rx_fifo_if.sv - APB request/response bundle for the receive frame FIFO
interface apb_rx_fifo_if #(
   parameter int ADDRESSWIDTH = 3,
   parameter int DATAWIDTH    = 16
);
   logic [ADDRESSWIDTH-1:0] PADDR_rx_i;
   logic                    PWRITE_rx_i;
   logic                    PSELx_rx_i;
   logic                    PENABLE_rx_i;
   logic [DATAWIDTH-1:0]    PWDATA_rx_i;
   logic [DATAWIDTH-1:0]    PRDATA_rx_o;
   logic                    PREADY_rx_o;
   logic                    PSLVERR_rx_o;

   modport master (
      output PADDR_rx_i, PWRITE_rx_i, PSELx_rx_i, PENABLE_rx_i, PWDATA_rx_i,
      input  PRDATA_rx_o, PREADY_rx_o, PSLVERR_rx_o
   );

   modport slave (
      input  PADDR_rx_i, PWRITE_rx_i, PSELx_rx_i, PENABLE_rx_i, PWDATA_rx_i,
      output PRDATA_rx_o, PREADY_rx_o, PSLVERR_rx_o
   );
endinterface

// File: rtl/apb_rx_fifo.sv
// rtl/apb_rx_fifo.sv - APB-readable receive frame FIFO with one wait state
// Optional interrupt logic is enabled by defining APB_RX_IRQ_EN.
module apb_rx_fifo #(
   parameter int ADDRESSWIDTH = 3,
   parameter int DATAWIDTH    = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        PCLK_rx,
   input  logic        PRESET_rx,
   apb_rx_fifo_if.slave apb,
   input  logic        frame_valid_rx_i,
   input  logic [7:0]  frame_id_rx_i,
   input  logic [7:0]  frame_cmd_rx_i,
   input  logic [15:0] frame_data_rx_i,
   output logic        irq_rx_o
);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;

   logic [31:0]          mem [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr, rd_ptr;
   logic [CW-1:0]        count;
   logic                 ovf, rx_en, irq_en, ack, slverr;
   logic [DATAWIDTH-1:0] rdata;

   logic                 access, empty, full, err, pop, flush, clr_ovf, ctrl_wr;
   logic                 push_req, do_push, ovf_set;
   logic [DATAWIDTH-1:0] rd_val;
   logic [31:0]          head;
   logic                 unused_wdata;

   assign access = apb.PSELx_rx_i & apb.PENABLE_rx_i & ~ack;
   assign empty  = (count == '0);
   assign full   = (count == CW'(FIFO_DEPTH));
   assign head   = mem[rd_ptr];
   assign unused_wdata = ^apb.PWDATA_rx_i;

   assign apb.PREADY_rx_o  = ack;
   assign apb.PSLVERR_rx_o = slverr;
   assign apb.PRDATA_rx_o  = rdata;

   always_comb begin
      rd_val  = '0;
      err     = 1'b0;
      pop     = 1'b0;
      flush   = 1'b0;
      clr_ovf = 1'b0;
      ctrl_wr = 1'b0;
      if (access) begin
         case (apb.PADDR_rx_i)
            ADDRESSWIDTH'(0): begin
               if (apb.PWRITE_rx_i) err = 1'b1;
               else rd_val = DATAWIDTH'({8'(count), 5'b0, ovf, full, empty});
            end
            ADDRESSWIDTH'(1): begin
               if (apb.PWRITE_rx_i || empty) err = 1'b1;
               else rd_val = DATAWIDTH'({head[23:16], head[31:24]});
            end
            ADDRESSWIDTH'(2): begin
               if (apb.PWRITE_rx_i || empty) err = 1'b1;
               else begin
                  rd_val = DATAWIDTH'(head[15:0]);
                  pop    = 1'b1;
               end
            end
            ADDRESSWIDTH'(3): begin
               if (apb.PWRITE_rx_i) begin
                  ctrl_wr = 1'b1;
                  flush   = apb.PWDATA_rx_i[2];
                  clr_ovf = apb.PWDATA_rx_i[3];
               end else begin
                  rd_val = DATAWIDTH'({irq_en, rx_en});
               end
            end
            default: err = 1'b1;
         endcase
      end
   end

   // A flush swallows any frame arriving on the same edge, so it cannot overflow either.
   assign push_req = frame_valid_rx_i & rx_en & ~flush;
   assign do_push  = push_req & (~full | pop);
   assign ovf_set  = push_req & full & ~pop;

   always_ff @(posedge PCLK_rx) begin
      if (PRESET_rx) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
         rx_en  <= 1'b0;
         ack    <= 1'b0;
         slverr <= 1'b0;
         rdata  <= '0;
      end else begin
         ack    <= access;
         slverr <= access & err;
         if (access && !apb.PWRITE_rx_i) rdata <= rd_val;
         if (ctrl_wr) rx_en <= apb.PWDATA_rx_i[0];
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !pop)      count <= count + 1'b1;
            else if (!do_push && pop) count <= count - 1'b1;
         end
         if (ovf_set)      ovf <= 1'b1;
         else if (clr_ovf) ovf <= 1'b0;
      end
   end

   always_ff @(posedge PCLK_rx) begin
      if (!PRESET_rx && do_push && !flush)
         mem[wr_ptr] <= {frame_id_rx_i, frame_cmd_rx_i, frame_data_rx_i};
   end

`ifdef APB_RX_IRQ_EN
   always_ff @(posedge PCLK_rx) begin
      if (PRESET_rx) begin
         irq_en   <= 1'b0;
         irq_rx_o <= 1'b0;
      end else begin
         if (ctrl_wr) irq_en <= apb.PWDATA_rx_i[1];
         irq_rx_o <= irq_en & (~empty | ovf);
      end
   end
`else
   assign irq_en   = 1'b0;
   assign irq_rx_o = 1'b0;
`endif
endmodule
